input_pixel_packer: RTL and testbench
=====================================

# input_pixel_packer

Front end of the histogram-equalization datapath. It accepts a frame of 8-bit pixels over a valid/ready byte stream and packs every 16 consecutive pixels into one 128-bit word. Each word is written into the M3 scratchpad, the same memory and 128-bit word format that the output pipeline's fetch stage later reads back. `input_base_offset` selects the bank, so a frame can be loaded into one bank while the output pipeline drains the other.

## Interface
- NUM_WORDS, 4096: 128-bit words per frame (16 × NUM_WORDS pixels); range 1..BANK_OFFSET.
- BANK_OFFSET, 4096: word-address offset applied when the bank select is 1.
- clock  input  1  system clock; all logic is on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse that begins a frame; honoured only in IDLE or DONE.
- input_base_offset  input  1  bank select; sampled on the cycle start is accepted.
- pixel_in  input  8  pixel data.
- pixel_valid  input  1  pixel_in is valid this cycle.
- pixel_ready  output  1  the block accepts a pixel this cycle.
- M3SP_WriteBus  output  128  packed word; pixel k of the group is in bits [8k+7:8k], first pixel in bits [7:0].
- M3SP_WriteAddress  output  16  word address.
- M3SP_WriteEnable  output  1  one-cycle write strobe.
- done  output  1  frame fully written; held high until the next accepted start.

## Operation
- A pixel is accepted on any cycle where pixel_valid and pixel_ready are both high.
- States and transitions:
  - IDLE: start → PACK.
  - PACK: the 16·NUM_WORDS-th pixel is accepted → DRAIN.
  - DRAIN: the final write is issued → DONE.
  - DONE: start → PACK.
  - start is ignored in PACK and DRAIN.
- On start:
  - Clear lane_cnt (4 bits) and word_idx (clog2(NUM_WORDS) bits, minimum 1).
  - Latch bank = input_base_offset.
  - Clear done.
- PACK:
  - pixel_ready = 1.
  - Each accepted pixel is written into assembly register lane lane_cnt, then lane_cnt increments (modulo 16).
  - On the accept where lane_cnt = 15:
    - Copy the completed assembly word (including the current pixel) into the write register.
    - Set the write pending for the next cycle.
    - The assembly register is reused immediately, so there is no stall between groups.
- Write: M3SP_WriteAddress = word_idx + (bank ? BANK_OFFSET : 0), truncated to 16 bits. word_idx increments after each write.
- pixel_ready is 0 in IDLE, DRAIN and DONE. It is also 0 on the cycle after the final pixel is accepted.
- Gaps in pixel_valid are allowed at any point; state holds until the next accept.
- Changing input_base_offset mid-frame has no effect.
- Reset is valid at any time, including mid-frame:
  - All state returns to IDLE.
  - The partial word is discarded and no write is issued.
  - Outputs return to their reset values.

## Timing
- Reset values:
  - pixel_ready = 0.
  - M3SP_WriteEnable = 0.
  - M3SP_WriteBus = 0.
  - M3SP_WriteAddress = 0.
  - done = 0.
  - state = IDLE.
- Start to ready: pixel_ready rises on the cycle after start is sampled.
- Write latency: M3SP_WriteEnable is high for exactly one cycle, the cycle after the 16th pixel of a group is accepted.
  - Bus and address are valid in that cycle.
  - Bus and address hold their last value otherwise.
- Throughput: one pixel per cycle sustained, so one write every 16 cycles.
- done rises on the cycle after the final M3SP_WriteEnable.
- A start sampled in DONE clears done on the next cycle and raises pixel_ready on that same cycle.
- The memory is assumed to always accept a write; there is no write back-pressure.

## Test plan
- Reset, single word: NUM_WORDS = 1, bank 0, start, 16 pixels of value 0x00..0x0F back-to-back.
  - One write: WE high once at address 0x0000, bus = 0x0F0E0D0C_0B0A0908_07060504_03020100.
  - done = 1 the following cycle.
- Bank 1, back-to-back groups: NUM_WORDS = 4, bank 1, 64 pixels of value i at index i, continuous.
  - Writes at 0x1000..0x1003, spaced exactly 16 cycles apart.
  - Word 2 bus = 0x2F2E..2120 (high to low).
  - pixel_ready stays high continuously until the 64th accept.
- Stalled input: as the single-word case, but pixel_valid randomly deasserted about 50% of cycles.
  - Identical write data and address; no extra or missing WE pulse.
- Ignored start and bank change: a second start pulse at pixel 5, and input_base_offset toggled mid-frame.
  - No restart; all addresses stay in the bank latched at the original start.
- Mid-frame reset: assert reset_n = 0 after 20 pixels of a 4-word frame.
  - Exactly one write was issued (0x0000) before reset; none after.
  - All outputs are 0 afterwards.
  - A new start then writes from address 0 with fresh data.
- Restart from DONE: after frame completion (done = 1), pulse start with bank 0.
  - done drops the next cycle, with pixel_ready rising the same cycle.
  - The second frame writes from 0x0000.

Source files
------------

// File: rtl/input_pixel_packer.sv
// input_pixel_packer: packs 16 consecutive 8-bit pixels into one 128-bit scratchpad word
// and writes NUM_WORDS such words into the bank selected when the frame starts.
module input_pixel_packer #(
  parameter int NUM_WORDS   = 4096,
  parameter int BANK_OFFSET = 4096
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic         input_base_offset,
  input  logic [7:0]   pixel_in,
  input  logic         pixel_valid,
  output logic         pixel_ready,
  output logic [127:0] M3SP_WriteBus,
  output logic [15:0]  M3SP_WriteAddress,
  output logic         M3SP_WriteEnable,
  output logic         done
);

  localparam int              WIDX      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [WIDX-1:0] LAST_WORD = WIDX'(NUM_WORDS - 1);
  localparam logic [15:0]     BANK_ADDR = 16'(BANK_OFFSET);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PACK  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      lane_q, lane_d;
  logic [WIDX-1:0] word_idx_q, word_idx_d;
  logic            bank_q, bank_d;
  logic [127:0]    asm_q, asm_d;
  logic            ready_q, ready_d;
  logic [127:0]    bus_q, bus_d;
  logic [15:0]     addr_q, addr_d;
  logic            we_q, we_d;
  logic            done_q, done_d;

  logic            accept_s;
  logic            group_end_s;
  logic [127:0]    word_full_s;

  // Next-state logic: frame sequencing, lane assembly and write-register loading.
  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    word_idx_d = word_idx_q;
    bank_d     = bank_q;
    asm_d      = asm_q;
    ready_d    = ready_q;
    bus_d      = bus_q;
    addr_d     = addr_q;
    we_d       = 1'b0;
    done_d     = done_q;

    accept_s    = pixel_valid && ready_q;
    group_end_s = accept_s && (lane_q == 4'd15);
    // The completed word must include the pixel accepted this cycle.
    word_full_s = asm_q;
    word_full_s[{lane_q, 3'b000} +: 8] = pixel_in;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_PACK;
          lane_d     = 4'd0;
          word_idx_d = '0;
          bank_d     = input_base_offset;
          ready_d    = 1'b1;
          done_d     = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      S_PACK: begin
        if (accept_s) begin
          asm_d  = word_full_s;
          lane_d = lane_q + 4'd1;
        end else begin
          asm_d = asm_q;
        end
        if (group_end_s) begin
          bus_d      = word_full_s;
          addr_d     = 16'(word_idx_q) + (bank_q ? BANK_ADDR : 16'd0);
          we_d       = 1'b1;
          word_idx_d = word_idx_q + WIDX'(1);
          if (word_idx_q == LAST_WORD) begin
            state_d = S_DRAIN;
            ready_d = 1'b0;
          end else begin
            state_d = S_PACK;
          end
        end else begin
          we_d = 1'b0;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any partially assembled word.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      lane_q     <= 4'd0;
      word_idx_q <= '0;
      bank_q     <= 1'b0;
      asm_q      <= 128'd0;
      ready_q    <= 1'b0;
      bus_q      <= 128'd0;
      addr_q     <= 16'd0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      word_idx_q <= word_idx_d;
      bank_q     <= bank_d;
      asm_q      <= asm_d;
      ready_q    <= ready_d;
      bus_q      <= bus_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      done_q     <= done_d;
    end
  end

  assign pixel_ready       = ready_q;
  assign M3SP_WriteBus     = bus_q;
  assign M3SP_WriteAddress = addr_q;
  assign M3SP_WriteEnable  = we_q;
  assign done              = done_q;

endmodule

// File: tb/tb_input_pixel_packer.sv
// Scoreboard bench for input_pixel_packer: one single-word instance (index 0) and one
// four-word instance (index 1) share clock, reset, pixel data and bank select.
module tb_input_pixel_packer;

  logic                  clock = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  bank = 1'b0;
  logic [7:0]            pix = 8'd0;
  logic [1:0]            start_r = 2'b00;
  logic [1:0]            valid_r = 2'b00;
  logic [1:0]            rdy_w, we_w, done_w;
  logic [1:0][127:0]     bus_w;
  logic [1:0][15:0]      addr_w;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int gap_cycles = 0;

  logic [127:0] lbus  [2][32];
  logic [15:0]  laddr [2][32];
  int           lt    [2][32];
  int           lcnt  [2] = '{0, 0};
  int           rd    [2] = '{0, 0};

  logic [143:0] exp0[$];
  logic [143:0] exp1[$];
  int           mcnt  [2];
  int           mwidx [2];
  logic         mbank [2];
  logic [127:0] mword [2];

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  input_pixel_packer #(.NUM_WORDS(1), .BANK_OFFSET(4096)) u_one (
    .clock(clock), .reset_n(reset_n), .start(start_r[0]), .input_base_offset(bank),
    .pixel_in(pix), .pixel_valid(valid_r[0]), .pixel_ready(rdy_w[0]),
    .M3SP_WriteBus(bus_w[0]), .M3SP_WriteAddress(addr_w[0]),
    .M3SP_WriteEnable(we_w[0]), .done(done_w[0])
  );

  input_pixel_packer #(.NUM_WORDS(4), .BANK_OFFSET(4096)) u_four (
    .clock(clock), .reset_n(reset_n), .start(start_r[1]), .input_base_offset(bank),
    .pixel_in(pix), .pixel_valid(valid_r[1]), .pixel_ready(rdy_w[1]),
    .M3SP_WriteBus(bus_w[1]), .M3SP_WriteAddress(addr_w[1]),
    .M3SP_WriteEnable(we_w[1]), .done(done_w[1])
  );

  // Write monitor: logs every write strobe with its cycle number.
  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (we_w[d] && lcnt[d] < 32) begin
        lbus[d][lcnt[d]]  = bus_w[d];
        laddr[d][lcnt[d]] = addr_w[d];
        lt[d][lcnt[d]]    = cyc;
        lcnt[d]           = lcnt[d] + 1;
      end
    end
  end

  task automatic do_start(input int d, input logic b);
    start_r[d] = 1'b1;
    bank       = b;
    mcnt[d]    = 0;
    mwidx[d]   = 0;
    mbank[d]   = b;
    @(negedge clock);
    start_r[d] = 1'b0;
  endtask

  task automatic send_pixels(input int d, input int n, input int base, input bit stall,
                             input int poke_at);
    int  sent = 0;
    int  guard = 0;
    int  lane;
    bit  started = 1'b0;
    bit  poked = 1'b0;
    logic [15:0] a;
    gap_cycles = 0;
    while (sent < n && guard < 4000) begin
      @(negedge clock);
      guard++;
      valid_r[d] = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      pix = 8'(base + sent);
      if (!poked && sent == poke_at) begin
        start_r[d] = 1'b1;
        bank       = ~bank;
        poked      = 1'b1;
      end else begin
        start_r[d] = 1'b0;
      end
      if (valid_r[d] && rdy_w[d]) begin
        lane = mcnt[d] % 16;
        mword[d][lane*8 +: 8] = pix;
        mcnt[d]++;
        sent++;
        started = 1'b1;
        if (lane == 15) begin
          a = (mbank[d] ? 16'h1000 : 16'h0000) + 16'(mwidx[d]);
          if (d == 0) exp0.push_back({a, mword[d]});
          else        exp1.push_back({a, mword[d]});
          mwidx[d]++;
        end
      end else if (started && !rdy_w[d]) begin
        gap_cycles++;
      end
    end
    checks++;
    if (sent != n) begin
      errors++;
      $display("FAIL send_timeout dut%0d: accepted %0d pixels, required %0d", d, sent, n);
    end
    @(negedge clock);
    valid_r[d] = 1'b0;
    start_r[d] = 1'b0;
  endtask

  task automatic score(input int d, input string tag);
    logic [143:0] e;
    int left;
    repeat (3) @(negedge clock);
    while (rd[d] < lcnt[d]) begin
      checks++;
      left = (d == 0) ? exp0.size() : exp1.size();
      if (left == 0) begin
        errors++;
        $display("FAIL %s extra_write: got addr %h bus %h, required no write", tag,
                 laddr[d][rd[d]], lbus[d][rd[d]]);
      end else begin
        e = (d == 0) ? exp0.pop_front() : exp1.pop_front();
        if ({laddr[d][rd[d]], lbus[d][rd[d]]} !== e) begin
          errors++;
          $display("FAIL %s write: got addr %h bus %h, required addr %h bus %h", tag,
                   laddr[d][rd[d]], lbus[d][rd[d]], e[143:128], e[127:0]);
        end
      end
      rd[d]++;
    end
    checks++;
    left = (d == 0) ? exp0.size() : exp1.size();
    if (left != 0) begin
      errors++;
      $display("FAIL %s missing_write: got %0d writes short, required 0", tag, left);
      if (d == 0) exp0.delete(); else exp1.delete();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({rdy_w[d], we_w[d], done_w[d], addr_w[d], bus_w[d]} !== 147'd0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: got rdy %b we %b done %b addr %h bus %h, required all 0",
                 d, rdy_w[d], we_w[d], done_w[d], addr_w[d], bus_w[d]);
      end
    end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_single_word();
    checks++;
    if (rdy_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready: got %b, required 0", rdy_w[0]);
    end
    do_start(0, 1'b0);
    checks++;
    if (rdy_w[0] !== 1'b1 || done_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL start_ready: got rdy %b done %b, required rdy 1 done 0", rdy_w[0], done_w[0]);
    end
    send_pixels(0, 16, 0, 1'b0, -1);
    checks++;
    if (we_w[0] !== 1'b1 || rdy_w[0] !== 1'b0 || done_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: got we %b rdy %b done %b, required we 1 rdy 0 done 0",
               we_w[0], rdy_w[0], done_w[0]);
    end
    checks++;
    if (bus_w[0] !== 128'h0F0E0D0C_0B0A0908_07060504_03020100 || addr_w[0] !== 16'h0000) begin
      errors++;
      $display("FAIL single_word: got addr %h bus %h, required addr 0000 bus 0f0e0d0c0b0a09080706050403020100",
               addr_w[0], bus_w[0]);
    end
    @(negedge clock);
    checks++;
    if (done_w[0] !== 1'b1 || we_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL single_done: got done %b we %b, required done 1 we 0", done_w[0], we_w[0]);
    end
    score(0, "single");
  endtask

  task automatic test_stalled();
    do_start(0, 1'b0);
    send_pixels(0, 16, 0, 1'b1, -1);
    checks++;
    if (we_w[0] !== 1'b1 || bus_w[0] !== 128'h0F0E0D0C_0B0A0908_07060504_03020100) begin
      errors++;
      $display("FAIL stalled_word: got we %b bus %h, required we 1 bus 0f0e0d0c0b0a09080706050403020100",
               we_w[0], bus_w[0]);
    end
    @(negedge clock);
    checks++;
    if (done_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL stalled_done: got %b, required 1", done_w[0]);
    end
    score(0, "stalled");
  endtask

  task automatic test_back_to_back();
    int b = lcnt[1];
    do_start(1, 1'b1);
    send_pixels(1, 64, 0, 1'b0, -1);
    checks++;
    if (gap_cycles != 0) begin
      errors++;
      $display("FAIL b2b_ready_gaps: got %0d low-ready cycles, required 0", gap_cycles);
    end
    checks++;
    if (we_w[1] !== 1'b1 || addr_w[1] !== 16'h1003 || rdy_w[1] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_last: got we %b addr %h rdy %b, required we 1 addr 1003 rdy 0",
               we_w[1], addr_w[1], rdy_w[1]);
    end
    @(negedge clock);
    checks++;
    if (done_w[1] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done: got %0b, required 1", done_w[1]);
    end
    score(1, "b2b");
    checks++;
    if (lbus[1][b+2] !== 128'h2F2E2D2C_2B2A2928_27262524_23222120 || laddr[1][b] !== 16'h1000) begin
      errors++;
      $display("FAIL b2b_word2: got bus %h first addr %h, required bus 2f2e2d2c2b2a29282726252423222120 addr 1000",
               lbus[1][b+2], laddr[1][b]);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (lt[1][b+k+1] - lt[1][b+k] != 16) begin
        errors++;
        $display("FAIL b2b_spacing%0d: got %0d cycles, required 16", k, lt[1][b+k+1] - lt[1][b+k]);
      end
    end
  endtask

  task automatic test_ignored_start();
    do_start(1, 1'b0);
    send_pixels(1, 64, 7, 1'b0, 5);
    checks++;
    if (we_w[1] !== 1'b1 || addr_w[1] !== 16'h0003 || gap_cycles != 0) begin
      errors++;
      $display("FAIL ignored_start_end: got we %b addr %h gaps %0d, required we 1 addr 0003 gaps 0",
               we_w[1], addr_w[1], gap_cycles);
    end
    @(negedge clock);
    checks++;
    if (done_w[1] !== 1'b1) begin
      errors++;
      $display("FAIL ignored_start_done: got %b, required 1", done_w[1]);
    end
    score(1, "ignored_start");
  endtask

  task automatic test_mid_reset();
    do_start(1, 1'b0);
    send_pixels(1, 20, 8'h40, 1'b0, -1);
    reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({rdy_w[d], we_w[d], done_w[d], addr_w[d], bus_w[d]} !== 147'd0) begin
        errors++;
        $display("FAIL midreset_outputs dut%0d: got rdy %b we %b done %b addr %h, required all 0",
                 d, rdy_w[d], we_w[d], done_w[d], addr_w[d]);
      end
    end
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({rdy_w[1], we_w[1], done_w[1], addr_w[1], bus_w[1]} !== 147'd0) begin
      errors++;
      $display("FAIL after_reset_outputs: got rdy %b we %b done %b addr %h, required all 0",
               rdy_w[1], we_w[1], done_w[1], addr_w[1]);
    end
    score(1, "midreset");
    do_start(1, 1'b0);
    send_pixels(1, 64, 8'h80, 1'b0, -1);
    @(negedge clock);
    checks++;
    if (done_w[1] !== 1'b1) begin
      errors++;
      $display("FAIL refill_done: got %b, required 1", done_w[1]);
    end
    score(1, "refill");
  endtask

  task automatic test_restart();
    do_start(0, 1'b1);
    send_pixels(0, 16, 8'h50, 1'b0, -1);
    checks++;
    if (we_w[0] !== 1'b1 || addr_w[0] !== 16'h1000) begin
      errors++;
      $display("FAIL restart_first: got we %b addr %h, required we 1 addr 1000", we_w[0], addr_w[0]);
    end
    @(negedge clock);
    checks++;
    if (done_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL restart_done_hi: got %b, required 1", done_w[0]);
    end
    do_start(0, 1'b0);
    checks++;
    if (done_w[0] !== 1'b0 || rdy_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL restart_edge: got done %b rdy %b, required done 0 rdy 1", done_w[0], rdy_w[0]);
    end
    send_pixels(0, 16, 8'h60, 1'b0, -1);
    checks++;
    if (we_w[0] !== 1'b1 || addr_w[0] !== 16'h0000) begin
      errors++;
      $display("FAIL restart_second: got we %b addr %h, required we 1 addr 0000", we_w[0], addr_w[0]);
    end
    score(0, "restart");
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_stalled();
    test_back_to_back();
    test_ignored_start();
    test_mid_reset();
    test_restart();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
